// File: rtl/mul_pkg.sv
// Shared types and constants for the HI/LO multiply unit: default widths,
// FSM state encoding and the MFHI/MFLO read-select codes.
package mul_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 6;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    localparam logic [1:0] SEL_ALU = 2'b00;
    localparam logic [1:0] SEL_HI  = 2'b01;
    localparam logic [1:0] SEL_LO  = 2'b10;

endpackage

// File: rtl/mul_step.sv
// One shift-add iteration of the unsigned multiplier: conditional add of the
// multiplicand into the upper half (with carry), then a 1-bit right shift.
module mul_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] prod_i,
    input  logic [WIDTH-1:0]   mcand_i,
    input  logic [WIDTH-1:0]   mplier_i,
    output logic [2*WIDTH-1:0] prod_o,
    output logic [WIDTH-1:0]   mplier_o
);

    logic [WIDTH:0] sum_c;

    always_comb begin
        sum_c    = {1'b0, prod_i[2*WIDTH-1:WIDTH]}
                 + (mplier_i[0] ? {1'b0, mcand_i} : (WIDTH+1)'(0));
        // The carry bit lands in the product MSB after the shift.
        prod_o   = (2*WIDTH)'({sum_c, prod_i[WIDTH-1:0]} >> 1);
        mplier_o = mplier_i >> 1;
    end

endmodule

// File: rtl/multu_hilo_unit.sv
// Multi-cycle MULTU/MADDU unit with architectural HI/LO and MFHI/MFLO read mux.
// Optional MULTU_EARLY_EXIT_EN: stop once the remaining multiplier is zero.
module multu_hilo_unit
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = mul_pkg::WIDTH,
    parameter int unsigned CNT_W = mul_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_maddu,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [1:0]       sel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] mf_data
);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic                 maddu_q, maddu_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;

    logic [2*WIDTH-1:0]   prod_step;
    logic [WIDTH-1:0]     mplier_step;
    logic                 last_c;
    logic [2*WIDTH-1:0]   result_c;

    mul_step #(.WIDTH(WIDTH)) u_step (
        .prod_i   (prod_q),
        .mcand_i  (mcand_q),
        .mplier_i (mplier_q),
        .prod_o   (prod_step),
        .mplier_o (mplier_step)
    );

    // Last-iteration detect and final alignment of the product.
    always_comb begin
`ifdef MULTU_EARLY_EXIT_EN
        last_c   = (cnt_q == CNT_W'(WIDTH-1)) || (mplier_step == '0);
        result_c = prod_step >> (CNT_W'(WIDTH-1) - cnt_q);
`else
        last_c   = (cnt_q == CNT_W'(WIDTH-1));
        result_c = prod_step;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            maddu_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            maddu_q  <= maddu_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start)  state_d = S_RUN;
            S_RUN:   if (last_c) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath updates: operand capture, iteration and HI/LO write-back.
    always_comb begin
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        maddu_d  = maddu_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d  = src_a;
                    mplier_d = src_b;
                    maddu_d  = op_maddu;
                    prod_d   = '0;
                    cnt_d    = '0;
                end
            end
            S_RUN: begin
                prod_d   = prod_step;
                mplier_d = mplier_step;
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_c) begin
                    {hi_d, lo_d} = maddu_q ? ({hi_q, lo_q} + result_c) : result_c;
                    done_d       = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        case (sel)
            SEL_HI:  mf_data = hi_q;
            SEL_LO:  mf_data = lo_q;
            default: mf_data = '0;
        endcase
    end

    assign busy = (state_q == S_RUN);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_multu_hilo_unit.sv
// Directed, table-driven bench for multu_hilo_unit (default build).
module tb_multu_hilo_unit;

    localparam int unsigned W = 32;
    localparam logic [1:0] S_ALU = 2'b00;
    localparam logic [1:0] S_HI  = 2'b01;
    localparam logic [1:0] S_LO  = 2'b10;
    localparam logic [1:0] S_NONE = 2'b11;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         op_maddu;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic [1:0]   sel;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [W-1:0] mf_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] model_hi = '0;
    logic [W-1:0] model_lo = '0;

    typedef struct {
        logic         maddu;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
    } vec_t;

    vec_t vecs[9];

    multu_hilo_unit dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op_maddu (op_maddu),
        .src_a    (src_a),
        .src_b    (src_b),
        .sel      (sel),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .mf_data  (mf_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Caller is just past a negedge; start is sampled on the next posedge (cycle 0).
    // inj_cyc != 0 drives a second (to-be-ignored) MULTU 2x2 in that cycle.
    task automatic run_op(input logic maddu, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] ehi, input logic [W-1:0] elo,
                          input int inj_cyc, input string name);
        int cyc;
        start    = 1'b1;
        op_maddu = maddu;
        src_a    = a;
        src_b    = b;
        sel      = S_LO;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        op_maddu = 1'($urandom);
        src_a    = $urandom;
        src_b    = $urandom;
        cyc      = 1;
        while (1) begin
            if (done) break;
            check({name, " busy"}, 64'(busy), 64'd1);
            if (cyc == 5) check({name, " mf_old_lo"}, 64'(mf_data), 64'(model_lo));
            if (cyc == inj_cyc) begin
                start = 1'b1; op_maddu = 1'b0; src_a = 32'd2; src_b = 32'd2;
            end else begin
                start = 1'b0;
            end
            if (cyc >= 40) begin
                check({name, " done_timeout"}, 64'(cyc), 64'd33);
                break;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({name, " done_cycle"}, 64'(cyc), 64'd33);
        check({name, " busy_in_done"}, 64'(busy), 64'd0);
        check({name, " hi"}, 64'(hi), 64'(ehi));
        check({name, " lo"}, 64'(lo), 64'(elo));
        sel = S_HI;  #1 check({name, " mfhi"}, 64'(mf_data), 64'(ehi));
        sel = S_LO;  #1 check({name, " mflo"}, 64'(mf_data), 64'(elo));
        sel = S_ALU; #1 check({name, " mf_alu"}, 64'(mf_data), 64'd0);
        sel = S_NONE; #1 check({name, " mf_none"}, 64'(mf_data), 64'd0);
        model_hi = ehi;
        model_lo = elo;
    endtask

    initial begin
        bit seen_done;

        vecs[0] = '{1'b0, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F};
        vecs[1] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2] = '{1'b1, 32'h0000_0002, 32'h0000_0003, 32'hFFFF_FFFE, 32'h0000_0007};
        vecs[3] = '{1'b1, 32'h3FFF_FFFF, 32'h0000_0008, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[4] = '{1'b1, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000};
        vecs[5] = '{1'b0, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_0000, 32'hFFFE_0001};
        vecs[6] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'hFFFE_0001};
        vecs[7] = '{1'b0, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
        vecs[8] = '{1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};

        rst = 1'b1; start = 1'b0; op_maddu = 1'b0; src_a = '0; src_b = '0; sel = S_HI;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        check("reset mf", 64'(mf_data), 64'd0);

        // Operations run back-to-back: each start lands in the previous done cycle.
        for (int i = 0; i < 9; i++)
            run_op(vecs[i].maddu, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo,
                   0, $sformatf("vec%0d", i));

        // Start while busy is ignored; the next start in the done cycle is accepted.
        run_op(1'b0, 32'd7, 32'd9, 32'd0, 32'h3F, 10, "ignore_busy");
        run_op(1'b0, 32'd4, 32'd4, 32'd0, 32'h10, 0, "back_to_back");

        // Reset mid-operation aborts with no done and clears HI/LO.
        start = 1'b1; op_maddu = 1'b0; src_a = 32'h1234; src_b = 32'h10;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        seen_done = 1'b0;
        for (int c = 1; c < 10; c++) begin
            if (done) seen_done = 1'b1;
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid busy", 64'(busy), 64'd0);
        check("rst_mid hi", 64'(hi), 64'd0);
        check("rst_mid lo", 64'(lo), 64'd0);
        for (int c = 0; c < 50; c++) begin
            if (done || busy) seen_done = 1'b1;
            @(negedge clk);
        end
        check("rst_mid no_done", 64'(seen_done), 64'd0);
        check("rst_mid lo_after", 64'(lo), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
